idex_operand_stage: RTL
=======================

Name: idex_operand_stage

Overview:
ID/EX pipeline register plus EX-stage operand forwarding for the 32-bit pipelined core.
- Captures decoded operands, register specifiers and control from decode.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Presents final srcA/srcB/alucontrol directly to the EX-stage ALU, and flags load-use hazards to the hazard unit.

Parameters:
WIDTH, 32, datapath width.
REGBITS, 5, register specifier width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush_e  in  1  insert bubble into EX on next edge
stall_e  in  1  hold ID/EX contents on next edge
id_ctrl  in  5  {regwrite, memtoreg, memwrite, alusrc, regdst}, bit 4 = regwrite
id_alucontrol  in  3  ALU function select from decode
id_rd1  in  WIDTH  register file read data, port 1
id_rd2  in  WIDTH  register file read data, port 2
id_signimm  in  WIDTH  sign-extended immediate
id_rs  in  REGBITS  rs specifier
id_rt  in  REGBITS  rt specifier
id_rd  in  REGBITS  rd specifier
mem_regwrite  in  1  MEM-stage instruction writes a register
mem_writereg  in  REGBITS  MEM-stage destination register
mem_aluout  in  WIDTH  MEM-stage ALU result
wb_regwrite  in  1  WB-stage instruction writes a register
wb_writereg  in  REGBITS  WB-stage destination register
wb_result  in  WIDTH  WB-stage result
ex_srca  out  WIDTH  ALU operand A
ex_srcb  out  WIDTH  ALU operand B
ex_alucontrol  out  3  ALU function select
ex_writedata  out  WIDTH  forwarded rt value, used for stores
ex_writereg  out  REGBITS  EX-stage destination register
ex_ctrl  out  3  {regwrite, memtoreg, memwrite} passed to EX/MEM
load_use_stall  out  1  load-use hazard request to the hazard unit

Behaviour:
- State: one register set holding id_ctrl, id_alucontrol, id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd.
- Register set updates on the rising clk edge. Latency ID->EX is 1 cycle.
- reset (async, active-high): all state cleared to 0 immediately. Resulting outputs:
  - ex_ctrl = 0, ex_alucontrol = 0, ex_writereg = 0, load_use_stall = 0.
  - ex_srca, ex_srcb and ex_writedata are 0 unless a forwarding match with a nonzero destination register exists.
- Edge priority: reset > flush_e > stall_e > load.
  - flush_e: all state cleared to 0. The result is a bubble: no register write, no memory write.
  - stall_e (without flush_e): state holds its value.
  - Otherwise: state loads the id_* inputs.
- Forwarding is combinational on the registered rs (rsE) and rt (rtE).
  - fwdA = mem_aluout if mem_regwrite && mem_writereg != 0 && mem_writereg == rsE.
  - Else fwdA = wb_result if wb_regwrite && wb_writereg != 0 && wb_writereg == rsE.
  - Else fwdA = registered rd1.
  - fwdB uses the same rules with rtE and registered rd2.
  - MEM always has priority over WB. Register 0 is never forwarded.
- ex_srca = fwdA. ex_writedata = fwdB.
- ex_srcb = registered alusrc ? registered signimm : fwdB.
- ex_writereg = registered regdst ? rdE : rtE.
- ex_alucontrol and ex_ctrl are the registered values.
- load_use_stall = registered memtoreg && ex_writereg != 0 && (ex_writereg == id_rs || ex_writereg == id_rt). This is combinational.
  - The block does not act on load_use_stall itself.
  - The hazard unit responds by stalling IF/ID and asserting flush_e.
- Outputs follow forwarding-input changes within the same cycle. No extra registering.

Test Plan:
- Assert reset mid-operation with nonzero state loaded -> ex_ctrl = 0, ex_writereg = 0, load_use_stall = 0 immediately, without waiting for clk.
- Load rd1 = 0x00000005, rd2 = 0x00000003, alusrc = 0, no forwarding matches -> after 1 edge, ex_srca = 5, ex_srcb = 3, ex_writedata = 3.
- rsE = 8; mem_writereg = 8 with mem_aluout = 0xAAAA0000; wb_writereg = 8 with wb_result = 0x12345678; both regwrite = 1 -> ex_srca = 0xAAAA0000. Deassert mem_regwrite -> ex_srca = 0x12345678.
- rtE = 0, mem_writereg = 0, mem_regwrite = 1 -> ex_writedata equals registered rd2, not mem_aluout. Then set alusrc = 1, signimm = 0xFFFFFFFC -> ex_srcb = 0xFFFFFFFC.
- Registered lw: memtoreg = 1, regdst = 0, rtE = 9. Present id_rs = 9 -> load_use_stall = 1. Assert flush_e for one edge -> ex_ctrl = 0 and load_use_stall = 0.
- With state loaded, assert stall_e for 2 edges while id_* inputs change -> outputs unchanged. Assert flush_e and stall_e together -> bubble (flush wins).

Source files
------------

// File: rtl/idex_operand_stage_if.sv
// idex_operand_stage_if
//   Groups the decode-side inputs, the MEM/WB forwarding taps and the
//   EX-side outputs of the ID/EX operand stage into one bundle.
//   master : the environment (decode, MEM/WB stages, hazard unit, EX ALU)
//   slave  : the idex_operand_stage block
//   Signals:
//     flush_e, stall_e             pipeline control from the hazard unit
//     id_ctrl[4:0]                 {regwrite, memtoreg, memwrite, alusrc, regdst}
//     id_alucontrol, id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd
//     mem_regwrite, mem_writereg, mem_aluout   MEM-stage forwarding tap
//     wb_regwrite, wb_writereg, wb_result      WB-stage forwarding tap
//     ex_srca, ex_srcb, ex_alucontrol, ex_writedata, ex_writereg, ex_ctrl
//     load_use_stall               load-use request to the hazard unit
interface idex_operand_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
);
  logic               flush_e;
  logic               stall_e;
  logic [4:0]         id_ctrl;
  logic [2:0]         id_alucontrol;
  logic [WIDTH-1:0]   id_rd1;
  logic [WIDTH-1:0]   id_rd2;
  logic [WIDTH-1:0]   id_signimm;
  logic [REGBITS-1:0] id_rs;
  logic [REGBITS-1:0] id_rt;
  logic [REGBITS-1:0] id_rd;
  logic               mem_regwrite;
  logic [REGBITS-1:0] mem_writereg;
  logic [WIDTH-1:0]   mem_aluout;
  logic               wb_regwrite;
  logic [REGBITS-1:0] wb_writereg;
  logic [WIDTH-1:0]   wb_result;
  logic [WIDTH-1:0]   ex_srca;
  logic [WIDTH-1:0]   ex_srcb;
  logic [2:0]         ex_alucontrol;
  logic [WIDTH-1:0]   ex_writedata;
  logic [REGBITS-1:0] ex_writereg;
  logic [2:0]         ex_ctrl;
  logic               load_use_stall;

  modport master (
    output flush_e, stall_e, id_ctrl, id_alucontrol, id_rd1, id_rd2,
           id_signimm, id_rs, id_rt, id_rd,
           mem_regwrite, mem_writereg, mem_aluout,
           wb_regwrite, wb_writereg, wb_result,
    input  ex_srca, ex_srcb, ex_alucontrol, ex_writedata, ex_writereg,
           ex_ctrl, load_use_stall
  );

  modport slave (
    input  flush_e, stall_e, id_ctrl, id_alucontrol, id_rd1, id_rd2,
           id_signimm, id_rs, id_rt, id_rd,
           mem_regwrite, mem_writereg, mem_aluout,
           wb_regwrite, wb_writereg, wb_result,
    output ex_srca, ex_srcb, ex_alucontrol, ex_writedata, ex_writereg,
           ex_ctrl, load_use_stall
  );
endinterface

// File: rtl/idex_operand_stage.sv
// idex_operand_stage
//   ID/EX pipeline register with EX-stage operand forwarding from MEM and WB,
//   plus load-use hazard detection against the instruction currently in ID.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears the whole register set
//     bus    idex_operand_stage_if.slave (decode inputs, forwarding taps,
//            EX outputs, load_use_stall)
module idex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  idex_operand_stage_if.slave  bus
);

  logic [4:0]         ctrl_q,       ctrl_d;
  logic [2:0]         alucontrol_q, alucontrol_d;
  logic [WIDTH-1:0]   rd1_q,        rd1_d;
  logic [WIDTH-1:0]   rd2_q,        rd2_d;
  logic [WIDTH-1:0]   signimm_q,    signimm_d;
  logic [REGBITS-1:0] rs_q,         rs_d;
  logic [REGBITS-1:0] rt_q,         rt_d;
  logic [REGBITS-1:0] rd_q,         rd_d;

  // Flush beats stall: a flushed slot becomes an all-zero bubble.
  always_comb begin
    ctrl_d       = ctrl_q;
    alucontrol_d = alucontrol_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    signimm_d    = signimm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    if (bus.flush_e) begin
      ctrl_d       = '0;
      alucontrol_d = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      signimm_d    = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
    end else if (!bus.stall_e) begin
      ctrl_d       = bus.id_ctrl;
      alucontrol_d = bus.id_alucontrol;
      rd1_d        = bus.id_rd1;
      rd2_d        = bus.id_rd2;
      signimm_d    = bus.id_signimm;
      rs_d         = bus.id_rs;
      rt_d         = bus.id_rt;
      rd_d         = bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q       <= '0;
      alucontrol_q <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      signimm_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      alucontrol_q <= alucontrol_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      signimm_q    <= signimm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
    end
  end

  logic               memtoreg_q, alusrc_q, regdst_q;
  logic               mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic [WIDTH-1:0]   fwd_a, fwd_b;
  logic [REGBITS-1:0] writereg;

  assign memtoreg_q = ctrl_q[3];
  assign alusrc_q   = ctrl_q[1];
  assign regdst_q   = ctrl_q[0];

  // Register 0 is hardwired to zero, so a write to it is never forwarded.
  assign mem_hit_a = bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == rs_q);
  assign wb_hit_a  = bus.wb_regwrite  && (bus.wb_writereg  != '0) && (bus.wb_writereg  == rs_q);
  assign mem_hit_b = bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == rt_q);
  assign wb_hit_b  = bus.wb_regwrite  && (bus.wb_writereg  != '0) && (bus.wb_writereg  == rt_q);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a = rd1_q;
    if (mem_hit_a)     fwd_a = bus.mem_aluout;
    else if (wb_hit_a) fwd_a = bus.wb_result;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (mem_hit_b)     fwd_b = bus.mem_aluout;
    else if (wb_hit_b) fwd_b = bus.wb_result;
  end

  assign writereg = regdst_q ? rd_q : rt_q;

  assign bus.ex_srca        = fwd_a;
  assign bus.ex_srcb        = alusrc_q ? signimm_q : fwd_b;
  assign bus.ex_writedata   = fwd_b;
  assign bus.ex_alucontrol  = alucontrol_q;
  assign bus.ex_writereg    = writereg;
  assign bus.ex_ctrl        = ctrl_q[4:2];

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; the hazard unit stalls IF/ID and flushes EX.
  assign bus.load_use_stall = memtoreg_q && (writereg != '0) &&
                              ((writereg == bus.id_rs) || (writereg == bus.id_rt));

endmodule
